// File: rtl/exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : exec_stage
// Purpose  : Execute/writeback stage: 8-bit ALU plus iterative shift-add MUL,
//            drives the register file write port through a one-op handshake.
// Revision : 1.0  initial release
// ============================================================================
module exec_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [2:0] op_i,
  input  logic [2:0] destReg_i,
  input  logic [7:0] operandA_i,
  input  logic [7:0] operandB_i,
  output logic       ready_o,
  output logic       writeFlag_o,
  output logic [2:0] destReg_o,
  output logic [7:0] data_o,
  output logic       carry_o,
  output logic       zero_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic [1:0]  state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [2:0]  dest_q, dest_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] partial;
  logic [8:0]  alu_res;
  logic        wb_go;
  logic [7:0]  wb_data;
  logic        wb_carry;

  logic        ready_q, wf_q, carry_q, zero_q;
  logic [2:0]  wdest_q;
  logic [7:0]  data_q;

  // {carry, result} for the single-cycle ops, taken straight from the issue port
  always_comb begin
    case (op_i)
      OP_ADD:  alu_res = {1'b0, operandA_i} + {1'b0, operandB_i};
      OP_SUB:  alu_res = {1'b0, operandA_i} - {1'b0, operandB_i};
      OP_AND:  alu_res = {1'b0, operandA_i & operandB_i};
      OP_OR:   alu_res = {1'b0, operandA_i | operandB_i};
      OP_XOR:  alu_res = {1'b0, operandA_i ^ operandB_i};
      OP_SHL:  alu_res = {1'b0, operandA_i << operandB_i[2:0]};
      OP_SHR:  alu_res = {1'b0, operandA_i >> operandB_i[2:0]};
      default: alu_res = 9'd0;
    endcase
  end

  assign partial = b_q[step_q] ? ({8'd0, a_q} << step_q) : 16'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      dest_q  <= 3'd0;
      step_q  <= 3'd0;
      acc_q   <= 16'd0;
      ready_q <= 1'b1;
      wf_q    <= 1'b0;
      wdest_q <= 3'd0;
      data_q  <= 8'd0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dest_q  <= dest_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      ready_q <= (state_d == S_IDLE);
      wf_q    <= wb_go;
      if (wb_go) begin
        wdest_q <= dest_d;
        data_q  <= wb_data;
        carry_q <= wb_carry;
        zero_q  <= (wb_data == 8'd0);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    dest_d   = dest_q;
    step_d   = step_q;
    acc_d    = acc_q;
    wb_go    = 1'b0;
    wb_data  = data_q;
    wb_carry = carry_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          a_d    = operandA_i;
          b_d    = operandB_i;
          dest_d = destReg_i;
          if (op_i == OP_MUL) begin
            acc_d   = 16'd0;
            step_d  = 3'd0;
            state_d = S_MUL;
          end else begin
            wb_go    = 1'b1;
            wb_data  = alu_res[7:0];
            wb_carry = alu_res[8];
            state_d  = S_WB;
          end
        end
      end
      S_MUL: begin
        acc_d  = acc_q + partial;
        step_d = step_q + 3'd1;
        // Last step writes back from the accumulator value being formed now
        if (step_q == 3'd7) begin
          wb_go    = 1'b1;
          wb_data  = acc_d[7:0];
          wb_carry = |acc_d[15:8];
          state_d  = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o     = ready_q;
    writeFlag_o = wf_q;
    destReg_o   = wdest_q;
    data_o      = data_q;
    carry_o     = carry_q;
    zero_o      = zero_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_stage
// Purpose  : Scoreboard bench for exec_stage with a small register file model.
// Revision : 1.0  initial release
// ============================================================================
module tb_exec_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_r = 1'b0;
  logic [2:0] op_r = 3'd0, dest_r = 3'd0;
  logic [7:0] a_r = 8'd0, b_r = 8'd0;
  logic       use_rf = 1'b0;
  logic [2:0] ra = 3'd0, rb = 3'd0;
  logic [7:0] opa_w, opb_w;

  logic       ready_o, writeFlag_o, carry_o, zero_o;
  logic [2:0] destReg_o;
  logic [7:0] data_o;

  logic [7:0] rf [8];
  int cyc = 0;
  int nwr = 0;
  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [2:0] dest;
    logic [7:0] data;
    logic       c;
    logic       z;
    int         cyc;
  } exp_t;
  exp_t q[$];

  assign opa_w = use_rf ? rf[ra] : a_r;
  assign opb_w = use_rf ? rf[rb] : b_r;

  exec_stage dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_r),
    .op_i       (op_r),
    .destReg_i  (dest_r),
    .operandA_i (opa_w),
    .operandB_i (opb_w),
    .ready_o    (ready_o),
    .writeFlag_o(writeFlag_o),
    .destReg_o  (destReg_o),
    .data_o     (data_o),
    .carry_o    (carry_o),
    .zero_o     (zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {carry, zero, data}
  function automatic logic [9:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    logic [7:0]  d;
    logic        c;
    c = 1'b0;
    p = 16'd0;
    case (op)
      3'd0: begin p = 16'(a) + 16'(b); d = p[7:0]; c = p[8]; end
      3'd1: begin d = a - b; c = (a < b); end
      3'd2: d = a & b;
      3'd3: d = a | b;
      3'd4: d = a ^ b;
      3'd5: d = a << b[2:0];
      3'd6: d = a >> b[2:0];
      default: begin p = 16'(a) * 16'(b); d = p[7:0]; c = |p[15:8]; end
    endcase
    return {c, (d == 8'd0), d};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (writeFlag_o) rf[destReg_o] <= data_o;
  end

  // Expected results are pushed at the accepting edge
  always @(posedge clk) begin
    if (!rst && valid_r && ready_o) begin
      exp_t e;
      logic [9:0] r;
      r     = model(op_r, opa_w, opb_w);
      e.dest = dest_r;
      e.data = r[7:0];
      e.z    = r[8];
      e.c    = r[9];
      e.cyc  = cyc + 1 + ((op_r == 3'd7) ? 8 : 0);
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (writeFlag_o) begin
      nwr++;
      if (q.size() == 0) begin
        check("unexpected_write", 32'(writeFlag_o), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("data",  32'(data_o),    32'(e.data));
        check("dest",  32'(destReg_o), 32'(e.dest));
        check("carry", 32'(carry_o),   32'(e.c));
        check("zero",  32'(zero_o),    32'(e.z));
        check("wb_cycle", 32'(cyc),    32'(e.cyc));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) check("ready_timeout", 32'(ready_o), 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [7:0] a, input logic [7:0] b);
    int n;
    @(negedge clk);
    op_r = op; dest_r = d; a_r = a; b_r = b; valid_r = 1'b1;
    wait_ready();
    @(negedge clk);
    // scramble the issue port after accept; captured operands must be used
    valid_r = 1'b0;
    op_r = 3'($urandom); dest_r = 3'($urandom); a_r = 8'($urandom); b_r = 8'($urandom);
    n = 0;
    while (!ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("ready_low_cycles", 32'(n), (op == 3'd7) ? 32'd9 : 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(ready_o),     32'd1);
    check({tag, "_wf"},    32'(writeFlag_o), 32'd0);
    check({tag, "_dest"},  32'(destReg_o),   32'd0);
    check({tag, "_data"},  32'(data_o),      32'd0);
    check({tag, "_carry"}, 32'(carry_o),     32'd0);
    check({tag, "_zero"},  32'(zero_o),      32'd0);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 8; i++) rf[i] = 8'(i);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    issue(3'd0, 3'd3, 8'hF0, 8'h20);
    issue(3'd1, 3'd2, 8'h05, 8'h05);
    issue(3'd1, 3'd4, 8'h03, 8'h05);
    issue(3'd7, 3'd5, 8'h0F, 8'h11);
    issue(3'd7, 3'd6, 8'h20, 8'h10);
    issue(3'd5, 3'd7, 8'h81, 8'h09);
    issue(3'd6, 3'd0, 8'h81, 8'h07);
    issue(3'd4, 3'd1, 8'hAA, 8'hFF);
    issue(3'd2, 3'd2, 8'h3C, 8'h0F);
    issue(3'd3, 3'd3, 8'h3C, 8'h0F);
    issue(3'd7, 3'd4, 8'hFF, 8'hFF);
    for (int i = 0; i < 8; i++)
      issue(3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));

    // Read-after-write through the register file, valid held across WB
    @(negedge clk);
    wait_ready();
    rf[1] = 8'h07;
    use_rf = 1'b1; ra = 3'd1; rb = 3'd1;
    w0 = nwr;
    op_r = 3'd0; dest_r = 3'd1; valid_r = 1'b1;
    repeat (3) @(negedge clk);
    valid_r = 1'b0;
    repeat (3) @(negedge clk);
    use_rf = 1'b0;
    check("raw_rf1", 32'(rf[1]), 32'h1C);
    check("raw_write_count", 32'(nwr - w0), 32'd2);

    // Reset pulsed at MUL step 4 aborts the operation
    @(negedge clk);
    op_r = 3'd7; dest_r = 3'd6; a_r = 8'h13; b_r = 8'h57; valid_r = 1'b1;
    wait_ready();
    @(negedge clk);
    valid_r = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    check_reset_values("abort");
    w0 = nwr;
    repeat (12) @(negedge clk);
    check("abort_no_write", 32'(nwr - w0), 32'd0);
    issue(3'd0, 3'd2, 8'h11, 8'h22);

    begin
      int n = 0;
      while (q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exec_stage.md
# exec_stage

Execute/writeback stage that sits directly downstream of the 8x8 register file. It consumes the two read-port operands, performs one of eight 8-bit operations (single-cycle ALU ops or an iterative 8-step shift-add multiply), and drives the register file write port (`destReg`, `writeFlag`, `data`) with the result. A ready/valid issue handshake keeps at most one operation in flight, so no forwarding path is needed.

## Interface
Parameters: none. Widths are fixed at 8-bit data and 3-bit register index.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `valid_i`  in  1  issue request. Sampled only while `ready_o`=1.
- `op_i`  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- `destReg_i`  in  3  destination register index.
- `operandA_i`  in  8  first operand, from register file `data1_o`.
- `operandB_i`  in  8  second operand, from register file `data2_o`.
- `ready_o`  out  1  high only in IDLE; the block can accept an issue.
- `writeFlag_o`  out  1  one-cycle write strobe to the register file.
- `destReg_o`  out  3  write index. Valid while `writeFlag_o`=1.
- `data_o`  out  8  write data. Valid while `writeFlag_o`=1.
- `carry_o`  out  1  carry flag, updated at each writeback.
- `zero_o`  out  1  zero flag (`data_o`==0), updated at each writeback.

## Operation
- FSM states: IDLE, MUL, WB.
- IDLE:
  - `ready_o`=1.
  - On `valid_i`=1, latch `op_i`, `destReg_i`, `operandA_i`, `operandB_i`.
  - If op≠MUL, compute the result and go to WB.
  - If op=MUL, clear the accumulator, load the step counter with 0, and go to MUL.
- MUL (8 cycles, step k=0..7):
  - If B[k]=1, add (A<<k) into a 16-bit accumulator.
  - After step 7, go to WB.
  - Result is `acc[7:0]`. Carry is the OR of `acc[15:8]`.
- WB:
  - `writeFlag_o`=1 for exactly one cycle, with `destReg_o`/`data_o` holding the result.
  - `carry_o`/`zero_o` update on entry to WB.
  - Return to IDLE.
- Width and flag rules, all results truncated to 8 bits:
  - ADD: carry = bit 8 of the 9-bit sum.
  - SUB: A−B mod 256; carry = borrow (A<B).
  - AND/OR/XOR: carry=0.
  - SHL/SHR: shift amount is `operandB_i[2:0]` (0..7); carry=0.
- Operands are captured at accept. Later changes on `operandA_i`/`operandB_i`/`op_i` have no effect.
- `valid_i` while `ready_o`=0 is ignored and not queued. The upstream side holds the request until it sees `ready_o`=1.
- Read-after-write: `ready_o` stays 0 through WB. The next accept therefore happens after the register file write edge, and the operands reflect the new value.
- `destReg_o`/`data_o` keep their last value outside WB and are qualified only by `writeFlag_o`.

## Timing
- Reset values: state=IDLE, `ready_o`=1, `writeFlag_o`=0, `destReg_o`=0, `data_o`=0, `carry_o`=0, `zero_o`=0.
- Reset takes priority over everything. A reset asserted mid-MUL or during WB aborts the operation: no write, no flag update, IDLE on the next edge. A `writeFlag_o` already high is 0 after the reset edge.
- ALU op accepted at edge N: `writeFlag_o`=1 during cycle N..N+1, `ready_o`=1 again after edge N+1. Throughput is 1 op per 2 cycles.
- MUL accepted at edge N: MUL occupies N..N+8, `writeFlag_o`=1 during N+8..N+9, `ready_o`=1 after edge N+9.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then ADD A=0xF0, B=0x20, dest=3 → one-cycle `writeFlag_o` with `data_o`=0x10, `destReg_o`=3, `carry_o`=1, `zero_o`=0, exactly 1 cycle after accept.
- SUB A=0x05, B=0x05 → `data_o`=0x00, `zero_o`=1, `carry_o`=0. Then SUB A=0x03, B=0x05 → 0xFE, `carry_o`=1.
- MUL A=0x0F, B=0x11 → `ready_o` low for 9 cycles, write on cycle 9, `data_o`=0xFF, `carry_o`=0. MUL A=0x20, B=0x10 → `data_o`=0x00, `carry_o`=1, `zero_o`=1.
- Back-to-back with the register file: ADD r1=r1+r1 issued twice with r1=0x07 → second write is 0x1C, proving read-after-write ordering. `valid_i` held high through WB is accepted only once per IDLE.
- SHL A=0x81, B=0x09 (amount 1) → 0x02. SHR A=0x81, B=0x07 → 0x01. XOR A=0xAA, B=0xFF → 0x55.
- `rst` pulsed at MUL step 4 → no `writeFlag_o` pulse, all outputs at reset values, and the next ADD completes normally.
